// File: rtl/audio_channel_mixer.sv
// Purpose: snapshot a frame of NUM_CH samples, apply Q2.14 gains, route to L/R sums, saturate to stereo out.
// Latency: frame accepted at edge T -> out_valid high after edge T+NUM_CH+1 (one channel per cycle).
// Backpressure: out_valid/out_left/out_right hold until out_ready; in_ready stays low until the pair is taken.
module audio_channel_mixer #(
    parameter int NUM_CH      = 4,
    parameter int AUDIO_WIDTH = 24,
    parameter int GAIN_WIDTH  = 16
) (
    input  logic                          clk_100mhz,
    input  logic                          resetn,
    input  logic [NUM_CH*AUDIO_WIDTH-1:0] in_samples,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*GAIN_WIDTH-1:0]  gain,
    input  logic [NUM_CH-1:0]             ch_enable,
    input  logic [NUM_CH-1:0]             route_left,
    input  logic [NUM_CH-1:0]             route_right,
    output logic [AUDIO_WIDTH-1:0]        out_left,
    output logic [AUDIO_WIDTH-1:0]        out_right,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          clip_clear,
    output logic                          clip_flag
);

    localparam int PW   = AUDIO_WIDTH + GAIN_WIDTH;
    localparam int ACCW = PW + $clog2(NUM_CH) + 1;
    localparam int KW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FRAC = GAIN_WIDTH - 2;
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-AUDIO_WIDTH+1){1'b0}}, {(AUDIO_WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-AUDIO_WIDTH+1){1'b1}}, {(AUDIO_WIDTH-1){1'b0}}};
    localparam logic [KW-1:0] K_LAST = KW'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

    state_t                          state_q, state_d;
    logic                            in_ready_q, in_ready_d;
    logic [NUM_CH*AUDIO_WIDTH-1:0]   samp_q, samp_d;
    logic [NUM_CH*GAIN_WIDTH-1:0]    gain_q, gain_d;
    logic [NUM_CH-1:0]               mask_l_q, mask_l_d;
    logic [NUM_CH-1:0]               mask_r_q, mask_r_d;
    logic [KW-1:0]                   k_q, k_d;
    logic signed [ACCW-1:0]          acc_l_q, acc_l_d;
    logic signed [ACCW-1:0]          acc_r_q, acc_r_d;
    logic                            out_valid_q, out_valid_d;
    logic [AUDIO_WIDTH-1:0]          out_left_q, out_left_d;
    logic [AUDIO_WIDTH-1:0]          out_right_q, out_right_d;
    logic                            clip_q, clip_d;

    logic [AUDIO_WIDTH-1:0]          cur_s;
    logic [GAIN_WIDTH-1:0]           cur_g;
    logic [PW-1:0]                   prod;
    logic signed [PW-1:0]            term;
    logic signed [ACCW-1:0]          term_ext;
    logic                            sat_l, sat_r;

    // Clamp a wide accumulator to the signed output range.
    function automatic logic [AUDIO_WIDTH-1:0] saturate(input logic signed [ACCW-1:0] a);
        if (a > SAT_MAX)
            saturate = SAT_MAX[AUDIO_WIDTH-1:0];
        else if (a < SAT_MIN)
            saturate = SAT_MIN[AUDIO_WIDTH-1:0];
        else
            saturate = a[AUDIO_WIDTH-1:0];
    endfunction

    // Channel k product: sign-extended multiply (exact in PW bits), then floor shift out the Q2.14 fraction.
    always_comb begin
        cur_s    = samp_q[int'(k_q)*AUDIO_WIDTH +: AUDIO_WIDTH];
        cur_g    = gain_q[int'(k_q)*GAIN_WIDTH +: GAIN_WIDTH];
        prod     = {{GAIN_WIDTH{cur_s[AUDIO_WIDTH-1]}}, cur_s} * {{AUDIO_WIDTH{cur_g[GAIN_WIDTH-1]}}, cur_g};
        term     = $signed(prod) >>> FRAC;
        term_ext = {{(ACCW-PW){term[PW-1]}}, term};
        sat_l    = (acc_l_q > SAT_MAX) || (acc_l_q < SAT_MIN);
        sat_r    = (acc_r_q > SAT_MAX) || (acc_r_q < SAT_MIN);
    end

    // Frame sequencing: accept/snapshot, per-channel accumulate, then present and hold the stereo pair.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        samp_d      = samp_q;
        gain_d      = gain_q;
        mask_l_d    = mask_l_q;
        mask_r_d    = mask_r_q;
        k_d         = k_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        out_valid_d = out_valid_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        clip_d      = clip_q;
        // Clear first so a saturation set later in this cycle takes priority.
        if (clip_clear)
            clip_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    samp_d     = in_samples;
                    gain_d     = gain;
                    mask_l_d   = ch_enable & route_left;
                    mask_r_d   = ch_enable & route_right;
                    acc_l_d    = '0;
                    acc_r_d    = '0;
                    k_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (mask_l_q[k_q])
                    acc_l_d = acc_l_q + term_ext;
                if (mask_r_q[k_q])
                    acc_r_d = acc_r_q + term_ext;
                k_d = k_q + 1'b1;
                if (k_q == K_LAST)
                    state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (!out_valid_q) begin
                    out_left_d  = saturate(acc_l_q);
                    out_right_d = saturate(acc_r_q);
                    out_valid_d = 1'b1;
                    if (sat_l || sat_r)
                        clip_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any frame in flight.
    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            samp_q      <= '0;
            gain_q      <= '0;
            mask_l_q    <= '0;
            mask_r_q    <= '0;
            k_q         <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            out_valid_q <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
            clip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            samp_q      <= samp_d;
            gain_q      <= gain_d;
            mask_l_q    <= mask_l_d;
            mask_r_q    <= mask_r_d;
            k_q         <= k_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            out_valid_q <= out_valid_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            clip_q      <= clip_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign clip_flag = clip_q;

endmodule
